// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the single-port memory arbiter.
package mem_arbiter_pkg;

    localparam int ADDR_WIDTH = 16;
    localparam int DATA_WIDTH = 8;
    localparam int BURST_LEN  = 4;
    localparam logic [15:0] ROM_BASE = 16'h8000;

    typedef enum logic [1:0] {
        IDLE,
        FBURST,
        FDRAIN,
        DREAD
    } state_t;

    typedef enum logic [1:0] {
        LD,
        DP,
        IF
    } req_id_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and memory-port bundle; slave is the arbiter's view, master the requester/memory side.
interface mem_arbiter_if #(
    parameter int ADDR_W = mem_arbiter_pkg::ADDR_WIDTH,
    parameter int DATA_W = mem_arbiter_pkg::DATA_WIDTH,
    parameter int BURST  = mem_arbiter_pkg::BURST_LEN
);

    logic                      fetch_req;
    logic [ADDR_W-1:0]         fetch_addr;
    logic                      fetch_gnt;
    logic                      fetch_valid;
    logic [BURST*DATA_W-1:0]   fetch_data;

    logic                      data_req;
    logic                      data_we;
    logic [ADDR_W-1:0]         data_addr;
    logic [DATA_W-1:0]         data_wdata;
    logic                      data_gnt;
    logic                      data_rvalid;
    logic [DATA_W-1:0]         data_rdata;

    logic                      ld_req;
    logic [ADDR_W-1:0]         ld_addr;
    logic [DATA_W-1:0]         ld_wdata;
    logic                      ld_gnt;

    logic                      mem_en;
    logic                      mem_we;
    logic [ADDR_W-1:0]         mem_addr;
    logic [DATA_W-1:0]         mem_wdata;
    logic [DATA_W-1:0]         mem_rdata;

    logic                      rom_fault;

    modport slave (
        input  fetch_req, fetch_addr,
        output fetch_gnt, fetch_valid, fetch_data,
        input  data_req, data_we, data_addr, data_wdata,
        output data_gnt, data_rvalid, data_rdata,
        input  ld_req, ld_addr, ld_wdata,
        output ld_gnt,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata,
        output rom_fault
    );

    modport master (
        output fetch_req, fetch_addr,
        input  fetch_gnt, fetch_valid, fetch_data,
        output data_req, data_we, data_addr, data_wdata,
        input  data_gnt, data_rvalid, data_rdata,
        output ld_req, ld_addr, ld_wdata,
        input  ld_gnt,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata,
        input  rom_fault
    );

endinterface

// File: rtl/mem_arbiter_arb_pick.sv
// Fair two-way pick between the CPU data port and instruction fetch.
module arb_pick
    import mem_arbiter_pkg::*;
(
    input  logic data_req,
    input  logic fetch_req,
    input  logic last_dp,
    output logic pick_dp,
    output logic pick_if
);

    // On a tie the side that was not granted most recently wins.
    assign pick_dp = data_req  && !(fetch_req && last_dp);
    assign pick_if = fetch_req && !(data_req && !last_dp);

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter/sequencer sharing one memory port between loader, CPU data port and atomic fetch bursts.
// Optional write protection of the upper half for the data port: MEM_ARB_ROM_PROTECT_EN.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = ADDR_WIDTH,
    parameter int DATA_W = DATA_WIDTH,
    parameter int BURST  = BURST_LEN
)
(
    input  logic            clk,
    input  logic            rst,
    mem_arbiter_if.slave    bus
);

    localparam int BEAT_W = $clog2(BURST);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST - 1);

    state_t                      state;
    logic [BEAT_W-1:0]           beat;
    logic                        last_dp;
    logic [ADDR_W-1:0]           base_addr;
    logic [(BURST-1)*DATA_W-1:0] beat_buf;

    logic                        fetch_valid_q;
    logic [BURST*DATA_W-1:0]     fetch_data_q;
    logic                        data_rvalid_q;
    logic [DATA_W-1:0]           data_rdata_q;

    logic                        pick_dp;
    logic                        pick_if;
    logic                        grant_any;
    req_id_t                     winner;
    logic                        ld_gnt;
    logic                        data_gnt;
    logic                        fetch_gnt;
    logic                        wr_blocked;

    logic                        mem_en;
    logic                        mem_we;
    logic [ADDR_W-1:0]           mem_addr;
    logic [DATA_W-1:0]           mem_wdata;

    arb_pick u_pick (
        .data_req  (bus.data_req),
        .fetch_req (bus.fetch_req),
        .last_dp   (last_dp),
        .pick_dp   (pick_dp),
        .pick_if   (pick_if)
    );

    // Grants only exist in IDLE and are forced low while reset is held.
    always_comb begin
        winner    = LD;
        grant_any = 1'b0;
        if (rst && state == IDLE) begin
            if (bus.ld_req) begin
                winner    = LD;
                grant_any = 1'b1;
            end else if (pick_dp) begin
                winner    = DP;
                grant_any = 1'b1;
            end else if (pick_if) begin
                winner    = IF;
                grant_any = 1'b1;
            end
        end
    end

    assign ld_gnt    = grant_any && (winner == LD);
    assign data_gnt  = grant_any && (winner == DP);
    assign fetch_gnt = grant_any && (winner == IF);

`ifdef MEM_ARB_ROM_PROTECT_EN
    assign wr_blocked = data_gnt && bus.data_we && bus.data_addr[ADDR_W-1];
`else
    assign wr_blocked = 1'b0;
`endif

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (rst) begin
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        case (winner)
                            LD: begin
                                mem_en    = 1'b1;
                                mem_we    = 1'b1;
                                mem_addr  = bus.ld_addr;
                                mem_wdata = bus.ld_wdata;
                            end
                            DP: begin
                                mem_addr = bus.data_addr;
                                if (bus.data_we) begin
                                    mem_en    = !wr_blocked;
                                    mem_we    = !wr_blocked;
                                    mem_wdata = bus.data_wdata;
                                end else begin
                                    mem_en = 1'b1;
                                end
                            end
                            IF: begin
                                mem_en   = 1'b1;
                                mem_addr = bus.fetch_addr;
                            end
                            default: ;
                        endcase
                    end
                end
                FBURST: begin
                    mem_en   = 1'b1;
                    mem_addr = base_addr + ADDR_W'(beat);
                end
                default: ;
            endcase
        end
    end

    // Sequencer: each FBURST cycle captures the byte read on the previous cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            beat          <= '0;
            last_dp       <= 1'b0;
            base_addr     <= '0;
            beat_buf      <= '0;
            fetch_valid_q <= 1'b0;
            fetch_data_q  <= '0;
            data_rvalid_q <= 1'b0;
            data_rdata_q  <= '0;
        end else begin
            fetch_valid_q <= 1'b0;
            data_rvalid_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (data_gnt) begin
                        last_dp <= 1'b1;
                        if (!bus.data_we) begin
                            state <= DREAD;
                        end
                    end else if (fetch_gnt) begin
                        last_dp   <= 1'b0;
                        base_addr <= bus.fetch_addr;
                        beat      <= BEAT_W'(1);
                        state     <= FBURST;
                    end
                end
                FBURST: begin
                    beat_buf[DATA_W*(int'(beat) - 1) +: DATA_W] <= bus.mem_rdata;
                    if (beat == LAST_BEAT) begin
                        beat  <= '0;
                        state <= FDRAIN;
                    end else begin
                        beat <= beat + 1'b1;
                    end
                end
                FDRAIN: begin
                    fetch_data_q  <= {bus.mem_rdata, beat_buf};
                    fetch_valid_q <= 1'b1;
                    state         <= IDLE;
                end
                DREAD: begin
                    data_rdata_q  <= bus.mem_rdata;
                    data_rvalid_q <= 1'b1;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.ld_gnt      = ld_gnt;
    assign bus.data_gnt    = data_gnt;
    assign bus.fetch_gnt   = fetch_gnt;
    assign bus.rom_fault   = wr_blocked;
    assign bus.mem_en      = mem_en;
    assign bus.mem_we      = mem_we;
    assign bus.mem_addr    = mem_addr;
    assign bus.mem_wdata   = mem_wdata;
    assign bus.fetch_valid = fetch_valid_q;
    assign bus.fetch_data  = fetch_data_q;
    assign bus.data_rvalid = data_rvalid_q;
    assign bus.data_rdata  = data_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural 64 KiB synchronous-read memory.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   check_count = 0;
    int   error_count = 0;

    logic [7:0] mem_array [0:65535];

    mem_arbiter_if bus ();

    mem_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we) mem_array[bus.mem_addr] <= bus.mem_wdata;
            else            bus.mem_rdata <= mem_array[bus.mem_addr];
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        check_count++;
        if (actual !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
        end
    endtask

    // One call = one cycle: inputs change just after the falling edge, then settle for 1 ns.
    task automatic applyStimulus(input logic ld, input logic [15:0] la, input logic [7:0] ldat,
                                 input logic dreq, input logic dwe, input logic [15:0] da,
                                 input logic [7:0] ddat, input logic freq, input logic [15:0] fa);
        @(negedge clk);
        bus.ld_req     = ld;
        bus.ld_addr    = la;
        bus.ld_wdata   = ldat;
        bus.data_req   = dreq;
        bus.data_we    = dwe;
        bus.data_addr  = da;
        bus.data_wdata = ddat;
        bus.fetch_req  = freq;
        bus.fetch_addr = fa;
        #1;
    endtask

    task automatic drive_idle();
        applyStimulus(0, 16'h0, 8'h0, 0, 0, 16'h0, 8'h0, 0, 16'h0);
    endtask

    task automatic ld_write(input logic [15:0] a, input logic [7:0] d);
        applyStimulus(1, a, d, 0, 0, 16'h0, 8'h0, 0, 16'h0);
        checkOutput("ld_gnt", 32'(bus.ld_gnt), 32'd1);
        checkOutput("ld_mem_we", 32'(bus.mem_we), 32'd1);
    endtask

    task automatic do_read(input logic [15:0] a, input logic [7:0] expected);
        applyStimulus(0, 16'h0, 8'h0, 1, 0, a, 8'h0, 0, 16'h0);
        checkOutput("rd_gnt", 32'(bus.data_gnt), 32'd1);
        checkOutput("rd_mem_en", 32'(bus.mem_en), 32'd1);
        drive_idle();
        drive_idle();
        checkOutput("rd_valid", 32'(bus.data_rvalid), 32'd1);
        checkOutput("rd_data", 32'(bus.data_rdata), 32'(expected));
        drive_idle();
        checkOutput("rd_valid_pulse", 32'(bus.data_rvalid), 32'd0);
        checkOutput("rd_data_hold", 32'(bus.data_rdata), 32'(expected));
    endtask

    // Cycles T+1..T+6 of a burst whose grant has already been checked.
    task automatic fetch_tail(input logic [15:0] a, input logic [31:0] expected);
        for (int k = 1; k < BURST_LEN; k++) begin
            logic [15:0] ak;
            ak = a + 16'(k);
            drive_idle();
            checkOutput("burst_addr", 32'(bus.mem_addr), 32'(ak));
            checkOutput("burst_gnt_blocked", 32'(bus.fetch_gnt | bus.ld_gnt | bus.data_gnt), 32'd0);
        end
        drive_idle();
        checkOutput("drain_mem_en", 32'(bus.mem_en), 32'd0);
        checkOutput("drain_no_valid", 32'(bus.fetch_valid), 32'd0);
        drive_idle();
        checkOutput("fetch_valid", 32'(bus.fetch_valid), 32'd1);
        checkOutput("fetch_data", bus.fetch_data, expected);
        drive_idle();
        checkOutput("fetch_valid_pulse", 32'(bus.fetch_valid), 32'd0);
        checkOutput("fetch_data_hold", bus.fetch_data, expected);
    endtask

    task automatic do_fetch(input logic [15:0] a, input logic [31:0] expected);
        applyStimulus(0, 16'h0, 8'h0, 0, 0, 16'h0, 8'h0, 1, a);
        checkOutput("fetch_gnt", 32'(bus.fetch_gnt), 32'd1);
        checkOutput("fetch_addr0", 32'(bus.mem_addr), 32'(a));
        fetch_tail(a, expected);
    endtask

    initial begin
        logic saw_valid;
        bus.ld_req = 0; bus.ld_addr = '0; bus.ld_wdata = '0;
        bus.data_req = 1; bus.data_we = 0; bus.data_addr = '0; bus.data_wdata = '0;
        bus.fetch_req = 1; bus.fetch_addr = '0;

        #12;
        checkOutput("rst_data_gnt", 32'(bus.data_gnt), 32'd0);
        checkOutput("rst_fetch_gnt", 32'(bus.fetch_gnt), 32'd0);
        checkOutput("rst_mem_en", 32'(bus.mem_en), 32'd0);
        checkOutput("rst_fetch_valid", 32'(bus.fetch_valid), 32'd0);
        checkOutput("rst_fetch_data", bus.fetch_data, 32'h0);
        checkOutput("rst_rvalid", 32'(bus.data_rvalid), 32'd0);
        checkOutput("rst_rdata", 32'(bus.data_rdata), 32'd0);
        checkOutput("rst_rom_fault", 32'(bus.rom_fault), 32'd0);
        bus.data_req  = 0;
        bus.fetch_req = 0;
        @(negedge clk);
        rst = 1;

        // Back-to-back loader preload, one byte per cycle.
        ld_write(16'h8000, 8'h01);
        ld_write(16'h8001, 8'h02);
        ld_write(16'h8002, 8'h03);
        ld_write(16'h8003, 8'h04);
        ld_write(16'hFFFE, 8'hAA);
        ld_write(16'hFFFF, 8'hBB);
        ld_write(16'h0000, 8'hCC);
        ld_write(16'h0001, 8'hDD);
        ld_write(16'h9000, 8'h33);
        drive_idle();

        do_fetch(16'h8000, 32'h04030201);
        do_fetch(16'hFFFE, 32'hDDCCBBAA);

        // Fresh reset so the tie-break flag starts at its reset value.
        rst = 0;
        drive_idle();
        drive_idle();
        rst = 1;
        applyStimulus(0, 16'h0, 8'h0, 1, 1, 16'h0100, 8'h5A, 1, 16'h8000);
        checkOutput("tie1_data_gnt", 32'(bus.data_gnt), 32'd1);
        checkOutput("tie1_fetch_gnt", 32'(bus.fetch_gnt), 32'd0);
        applyStimulus(0, 16'h0, 8'h0, 0, 0, 16'h0, 8'h0, 1, 16'h8000);
        checkOutput("tie1_fetch_next", 32'(bus.fetch_gnt), 32'd1);
        fetch_tail(16'h8000, 32'h04030201);
        applyStimulus(0, 16'h0, 8'h0, 1, 0, 16'h0100, 8'h0, 1, 16'hFFFE);
        checkOutput("tie2_data_gnt", 32'(bus.data_gnt), 32'd1);
        checkOutput("tie2_fetch_gnt", 32'(bus.fetch_gnt), 32'd0);
        applyStimulus(0, 16'h0, 8'h0, 0, 0, 16'h0, 8'h0, 1, 16'hFFFE);
        applyStimulus(0, 16'h0, 8'h0, 0, 0, 16'h0, 8'h0, 1, 16'hFFFE);
        checkOutput("tie2_rvalid", 32'(bus.data_rvalid), 32'd1);
        checkOutput("tie2_rdata", 32'(bus.data_rdata), 32'h5A);
        checkOutput("tie2_fetch_gnt_after", 32'(bus.fetch_gnt), 32'd1);
        checkOutput("tie2_fetch_addr", 32'(bus.mem_addr), 32'hFFFE);
        fetch_tail(16'hFFFE, 32'hDDCCBBAA);

        // Loader beats data port in the same cycle.
        applyStimulus(1, 16'h0200, 8'h11, 1, 1, 16'h0201, 8'h22, 0, 16'h0);
        checkOutput("ldvd_ld_gnt", 32'(bus.ld_gnt), 32'd1);
        checkOutput("ldvd_data_gnt", 32'(bus.data_gnt), 32'd0);
        checkOutput("ldvd_addr", 32'(bus.mem_addr), 32'h0200);
        applyStimulus(0, 16'h0, 8'h0, 1, 1, 16'h0201, 8'h22, 0, 16'h0);
        checkOutput("ldvd_data_next", 32'(bus.data_gnt), 32'd1);
        checkOutput("ldvd_data_addr", 32'(bus.mem_addr), 32'h0201);
        do_read(16'h0201, 8'h22);
        do_read(16'h0200, 8'h11);

        // Data-port write into the upper half.
        applyStimulus(0, 16'h0, 8'h0, 1, 1, ROM_BASE + 16'h1000, 8'h55, 0, 16'h0);
        checkOutput("rom_data_gnt", 32'(bus.data_gnt), 32'd1);
`ifdef MEM_ARB_ROM_PROTECT_EN
        checkOutput("rom_mem_we", 32'(bus.mem_we), 32'd0);
        checkOutput("rom_mem_en", 32'(bus.mem_en), 32'd0);
        checkOutput("rom_fault", 32'(bus.rom_fault), 32'd1);
        drive_idle();
        checkOutput("rom_fault_pulse", 32'(bus.rom_fault), 32'd0);
        do_read(16'h9000, 8'h33);
        ld_write(16'h9000, 8'h77);
        drive_idle();
        do_read(16'h9000, 8'h77);
`else
        checkOutput("rom_mem_we", 32'(bus.mem_we), 32'd1);
        checkOutput("rom_fault", 32'(bus.rom_fault), 32'd0);
        drive_idle();
        do_read(16'h9000, 8'h55);
`endif

        // Reset asserted at T+2 of a burst aborts it.
        applyStimulus(0, 16'h0, 8'h0, 0, 0, 16'h0, 8'h0, 1, 16'h8000);
        checkOutput("abort_fetch_gnt", 32'(bus.fetch_gnt), 32'd1);
        drive_idle();
        drive_idle();
        rst = 0;
        #1;
        checkOutput("abort_mem_en", 32'(bus.mem_en), 32'd0);
        checkOutput("abort_mem_addr", 32'(bus.mem_addr), 32'd0);
        checkOutput("abort_fetch_data", bus.fetch_data, 32'h0);
        saw_valid = 1'b0;
        for (int c = 0; c < 7; c++) begin
            drive_idle();
            if (c == 1) rst = 1;
            saw_valid = saw_valid | bus.fetch_valid | bus.data_rvalid;
        end
        checkOutput("abort_no_valid", 32'(saw_valid), 32'd0);
        do_fetch(16'h8000, 32'h04030201);

        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end

endmodule
